// File: rtl/online_result_collector_r4_pkg.sv
// ---------------------------------------------------------------------------
// online_r4_pkg
// Shared defaults and FSM state encoding for the online radix-4 result
// collector.
//   N_DEF     : operand digit count (the collector accepts N+1 result digits)
//   C_DEF     : bits per signed radix-4 digit
//   DELAY_DEF : online delay in digit strobes, skipped before collecting
//   W_DEF     : width of the converted two's-complement value
//   state_e   : collector states IDLE / SKIP / COLLECT / DONE
// ---------------------------------------------------------------------------
package online_r4_pkg;

    localparam int N_DEF     = 6;
    localparam int C_DEF     = 3;
    localparam int DELAY_DEF = 2;
    localparam int W_DEF     = 2 * (N_DEF + 1) + 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/online_result_collector_r4_if.sv
// ---------------------------------------------------------------------------
// online_result_collector_r4_if
// Bundles the control, digit and result signals of the collector.
//   start     : one-cycle pulse opening a new collection (driver -> collector)
//   en        : digit strobe, same as the online adder enable
//   zi        : signed radix-4 result digit, C bits
//   expected  : signed reference value, W bits
//   busy      : collector is in SKIP or COLLECT
//   done      : one-cycle completion pulse
//   result    : accepted digits packed MSD at top, (N+1)*C bits
//   value     : two's-complement conversion of result, W bits
//   correct   : value == expected, valid from done until next start
//   digit_err : sticky flag, illegal most-negative digit code seen
// Handshake: start and en are sampled on the rising clock edge; there is no
// back-pressure, so every en-high cycle in SKIP/COLLECT consumes one digit.
// modport master drives the inputs, modport slave is the collector itself.
// ---------------------------------------------------------------------------
interface online_result_collector_r4_if
    import online_r4_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF,
    parameter int W = W_DEF
);

    logic                   start;
    logic                   en;
    logic [C-1:0]           zi;
    logic [W-1:0]           expected;
    logic                   busy;
    logic                   done;
    logic [(N+1)*C-1:0]     result;
    logic [W-1:0]           value;
    logic                   correct;
    logic                   digit_err;

    modport master (
        output start, en, zi, expected,
        input  busy, done, result, value, correct, digit_err
    );

    modport slave (
        input  start, en, zi, expected,
        output busy, done, result, value, correct, digit_err
    );

endinterface

// File: rtl/online_result_collector_r4_accumulator.sv
// ---------------------------------------------------------------------------
// sd_r4_accumulator
// Horner conversion of a signed-digit radix-4 stream, MSD first:
//   value <= 4*value + sext(digit), W bits, wraps without saturation.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear_i      : synchronous clear (wins over load_i)
//   load_i       : accumulate digit_i this cycle
//   digit_i      : signed digit, C bits
//   value_o      : registered value
//   value_next_o : value that will be registered on the next edge, so the
//                  owner can compare the final value in the same cycle the
//                  last digit is accepted
// ---------------------------------------------------------------------------
module sd_r4_accumulator #(
    parameter int W = 16,
    parameter int C = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [C-1:0] digit_i,
    output logic [W-1:0] value_o,
    output logic [W-1:0] value_next_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W-1:0] digit_sext;

    assign digit_sext = {{(W-C){digit_i[C-1]}}, digit_i};

    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (load_i) begin
            value_d = {value_q[W-3:0], 2'b00} + digit_sext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o      = value_q;
    assign value_next_o = value_d;

endmodule

// File: rtl/online_result_collector_r4.sv
// ---------------------------------------------------------------------------
// online_result_collector_r4
// Collects the result digit stream of an online radix-4 adder: skips the
// first DELAY strobes (online delay), then accepts N+1 digits MSD first,
// packs them into result, converts them to two's complement in value and
// compares against expected.
// Ports:
//   clk         : single clock, all state on the rising edge
//   reset       : asynchronous active-high reset
//   bus         : online_result_collector_r4_if.slave (start/en/zi/expected
//                 in, busy/done/result/value/correct/digit_err out)
//   dbg_state_o : current FSM state (IDLE=0, SKIP=1, COLLECT=2, DONE=3)
// ---------------------------------------------------------------------------
module online_result_collector_r4
    import online_r4_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int C     = C_DEF,
    parameter int DELAY = DELAY_DEF,
    parameter int W     = 2 * (N + 1) + 2
) (
    input  logic                        clk,
    input  logic                        reset,
    online_result_collector_r4_if.slave bus,
    output logic [1:0]                  dbg_state_o
);

    localparam int CW = $clog2(N + 2);
    localparam int RW = (N + 1) * C;

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_SKIP    = ST_SKIP;
    localparam logic [1:0] S_COLLECT = ST_COLLECT;
    localparam logic [1:0] S_DONE    = ST_DONE;

    // Most negative C-bit code has no radix-4 digit meaning (-4 for C=3).
    localparam logic [C-1:0]  MOST_NEG  = {1'b1, {(C-1){1'b0}}};
    localparam logic [CW-1:0] SKIP_LAST = CW'((DELAY > 0) ? (DELAY - 1) : 0);
    localparam logic [CW-1:0] COLL_LAST = CW'(N);

    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [RW-1:0] result_q,  result_d;
    logic          done_q,    done_d;
    logic          correct_q, correct_d;
    logic          derr_q,    derr_d;

    logic          acc_clear;
    logic          acc_load;
    logic [W-1:0]  acc_value;
    logic [W-1:0]  acc_next;

    sd_r4_accumulator #(
        .W (W),
        .C (C)
    ) u_acc (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (acc_clear),
        .load_i       (acc_load),
        .digit_i      (bus.zi),
        .value_o      (acc_value),
        .value_next_o (acc_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        correct_d = correct_q;
        derr_d    = derr_q;
        acc_clear = 1'b0;
        acc_load  = 1'b0;

        // start restarts from any state and swallows a coincident strobe.
        if (bus.start) begin
            state_d   = (DELAY == 0) ? S_COLLECT : S_SKIP;
            cnt_d     = '0;
            result_d  = '0;
            correct_d = 1'b0;
            derr_d    = 1'b0;
            acc_clear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_SKIP: begin
                    if (bus.en) begin
                        if (cnt_q == SKIP_LAST) begin
                            state_d = S_COLLECT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (bus.en) begin
                        acc_load = 1'b1;
                        result_d = {result_q[RW-C-1:0], bus.zi};
                        if (bus.zi == MOST_NEG) begin
                            derr_d = 1'b1;
                        end
                        if (cnt_q == COLL_LAST) begin
                            state_d   = S_DONE;
                            cnt_d     = '0;
                            done_d    = 1'b1;
                            // Compare the value being loaded this edge so that
                            // correct is already valid while done is high.
                            correct_d = (acc_next == bus.expected);
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            correct_q <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
            correct_q <= correct_d;
            derr_q    <= derr_d;
        end
    end

    assign bus.busy      = (state_q == S_SKIP) || (state_q == S_COLLECT);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.value     = acc_value;
    assign bus.correct   = correct_q;
    assign bus.digit_err = derr_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_online_result_collector_r4.sv
// ---------------------------------------------------------------------------
// tb_online_result_collector_r4
// Directed bench for online_result_collector_r4 (N=6, C=3, DELAY=2, W=16).
// Each full run pushes its hand-computed value/result/flags onto expected
// queues; a negedge monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_online_result_collector_r4;

    localparam int N     = 6;
    localparam int C     = 3;
    localparam int DELAY = 2;
    localparam int W     = 16;
    localparam int RW    = (N + 1) * C;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    online_result_collector_r4_if #(.N(N), .C(C), .W(W)) bus ();

    online_result_collector_r4 #(
        .N     (N),
        .C     (C),
        .DELAY (DELAY),
        .W     (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int total     = 0;
    int bad       = 0;
    int done_seen = 0;

    logic [W-1:0]  exp_q[$];
    logic [RW-1:0] exp_res_q[$];
    logic [1:0]    exp_flag_q[$];   // {correct, digit_err}

    logic [W-1:0]  mon_v;
    logic [RW-1:0] mon_r;
    logic [1:0]    mon_f;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_v = exp_q.pop_front();
                mon_r = exp_res_q.pop_front();
                mon_f = exp_flag_q.pop_front();
                check("value", 64'(bus.value), 64'(mon_v));
                check("result", 64'(bus.result), 64'(mon_r));
                check("correct", 64'(bus.correct), 64'(mon_f[1]));
                check("digit_err", 64'(bus.digit_err), 64'(mon_f[0]));
            end
        end
    end

    // Full collection: start pulse, DELAY skip strobes, N+1 digits from digs
    // (MSD in the top C bits). stall drops en on even cycles with a poison
    // digit on zi; en_at_start raises en together with start.
    task automatic run(input logic [RW-1:0] digs, input logic [W-1:0] expv,
                       input logic [W-1:0] exp_val, input bit exp_corr,
                       input bit exp_derr, input bit stall,
                       input bit en_at_start, input int exp_lat);
        int strobes;
        int cyc;
        exp_q.push_back(exp_val);
        exp_res_q.push_back(digs);
        exp_flag_q.push_back({exp_corr, exp_derr});
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.en       = en_at_start;
        bus.zi       = 3'b011;
        bus.expected = expv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("derr_cleared_by_start", 64'(bus.digit_err), 64'd0);
        check("value_cleared_by_start", 64'(bus.value), 64'd0);
        strobes = 0;
        cyc     = 1;
        while (strobes < DELAY + N + 1) begin
            if (stall && (cyc % 2 == 0)) begin
                bus.en = 1'b0;
                bus.zi = 3'b100;
            end else begin
                bus.en = 1'b1;
                if (strobes < DELAY) bus.zi = 3'b001;
                else bus.zi = digs[RW-1-C*(strobes-DELAY) -: C];
                strobes++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.en = 1'b0;
        bus.zi = '0;
        check("done_now", 64'(bus.done), 64'd1);
        check("done_latency", 64'(cyc), 64'(exp_lat));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("busy_idle_after", 64'(bus.busy), 64'd0);
    endtask

    // Start and feed n strobes (skip strobes first, then digits) without
    // finishing the run.
    task automatic partial(input logic [RW-1:0] digs, input int n);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.en    = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.en = 1'b1;
            if (i < DELAY) bus.zi = 3'b001;
            else bus.zi = digs[RW-1-C*(i-DELAY) -: C];
            @(posedge clk); #1;
        end
        bus.en = 1'b0;
        bus.zi = '0;
    endtask

    initial begin
        int seen_before;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.en       = 1'b0;
        bus.zi       = '0;
        bus.expected = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_value", 64'(bus.value), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_correct", 64'(bus.correct), 64'd0);
        check("rst_digit_err", 64'(bus.digit_err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;

        // 1,-2,0,0,0,0,0 -> 2048
        run({3'b001, 3'b110, 15'b0}, 16'd2048, 16'h0800, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        // all +3 -> 16383
        run({7{3'b011}}, 16'h3FFF, 16'h3FFF, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        // all -3 -> -16383, compared against 0 so correct must be low
        run({7{3'b101}}, 16'h0000, 16'hC001, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        // stalled version of the first run: 8 idle cycles inserted
        run({3'b001, 3'b110, 15'b0}, 16'd2048, 16'h0800, 1'b1, 1'b0, 1'b1, 1'b0, 18);

        // en in IDLE must not disturb held outputs
        for (int i = 0; i < 4; i++) begin
            bus.en = 1'b1;
            bus.zi = 3'b011;
            @(posedge clk); #1;
        end
        bus.en = 1'b0;
        check("idle_value_held", 64'(bus.value), 64'h0800);
        check("idle_correct_held", 64'(bus.correct), 64'd1);
        check("idle_state", 64'(dbg_state), 64'd0);

        // -4 code in third digit: 1,0,-4,0,0,0,0 -> 3072, digit_err sticky
        run({3'b001, 3'b000, 3'b100, 12'b0}, 16'd3072, 16'h0C00, 1'b1, 1'b1, 1'b0, 1'b0, 10);
        check("derr_held_after_done", 64'(bus.digit_err), 64'd1);
        // next run clears it (checked inside run), and en with start is ignored
        run({3'b001, 3'b110, 15'b0}, 16'd2048, 16'h0800, 1'b1, 1'b0, 1'b0, 1'b1, 10);

        // abort after 4 accepted digits, then a full new run
        partial({7{3'b011}}, DELAY + 4);
        check("abort_busy", 64'(bus.busy), 64'd1);
        check("abort_no_done", 64'(bus.done), 64'd0);
        run({3'b001, 3'b110, 15'b0}, 16'd2048, 16'h0800, 1'b1, 1'b0, 1'b0, 1'b0, 10);

        // asynchronous reset mid-COLLECT
        partial({3'b011, 3'b100, 3'b011, 12'b0}, DELAY + 3);
        check("pre_reset_derr", 64'(bus.digit_err), 64'd1);
        seen_before = done_seen;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_value", 64'(bus.value), 64'd0);
        check("mid_rst_result", 64'(bus.result), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_derr", 64'(bus.digit_err), 64'd0);
        check("mid_rst_correct", 64'(bus.correct), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.en = 1'b1;
            bus.zi = 3'b001;
            @(posedge clk); #1;
        end
        bus.en = 1'b0;
        check("no_done_after_reset", 64'(done_seen), 64'(seen_before));
        check("idle_after_reset", 64'(dbg_state), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/online_result_collector_r4.md
ONLINE_RESULT_COLLECTOR_R4 -- requirements
Module: online_result_collector_r4

Interface
REQ-001 SHALL have parameter N, default 6, operand digit count.
REQ-002 SHALL have parameter C, default 3, bits per signed radix-4 digit.
REQ-003 SHALL have parameter DELAY, default 2, online delay in digit strobes.
REQ-004 SHALL have parameter W, default 2*(N+1)+2, width of converted value.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse opening a new collection.
REQ-008 SHALL have port en  input  1  digit strobe, identical to the adder enable.
REQ-009 SHALL have port zi  input  C  signed result digit from online_adder_r4.
REQ-010 SHALL have port expected  input  W  signed two's-complement reference value.
REQ-011 SHALL have port busy  output  1  high in SKIP or COLLECT.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port result  output  (N+1)*C  packed accepted digits, MSD at top.
REQ-014 SHALL have port value  output  W  signed two's-complement of result.
REQ-015 SHALL have port correct  output  1  value equals expected, valid from done.
REQ-016 SHALL have port digit_err  output  1  sticky, illegal digit seen.

Function
REQ-017 SHALL implement states IDLE, SKIP, COLLECT, DONE.
REQ-018 IDLE->SKIP on start; counters, result, value, digit_err cleared same edge.
REQ-019 SKIP SHALL discard zi for DELAY en-high cycles, then enter COLLECT; DELAY=0 goes straight to COLLECT.
REQ-020 COLLECT SHALL accept zi on each en-high cycle, MSD first, N+1 digits total.
REQ-021 Each accepted digit SHALL shift into result LSB end: result <= {result[(N*C)-1:0], zi}.
REQ-022 Each accepted digit SHALL update value <= 4*value + sext(zi) (Horner), W bits, no saturation.
REQ-023 After the (N+1)th accept SHALL enter DONE; done high exactly that one following cycle, then IDLE.
REQ-024 correct SHALL be registered in DONE as (value == expected), held until next start.
REQ-025 en low SHALL stall SKIP/COLLECT with no state, count or output change.
REQ-026 zi == most-negative code (3'b100 for C=3) SHALL set digit_err; digit still accumulated.
REQ-027 start during SKIP/COLLECT/DONE SHALL abort and restart as REQ-018; no done for aborted run.
REQ-028 start and en high same cycle: start wins, that strobe SHALL NOT be counted.
REQ-029 en in IDLE SHALL be ignored; result/value/correct held after done.
REQ-030 busy SHALL be combinational from state; done, correct registered.

Reset
REQ-031 reset SHALL force IDLE and clear busy, done, result, value, correct, digit_err, counters asynchronously.
REQ-032 reset mid-operation SHALL discard the run; no done afterwards.

Structure
REQ-033 Package online_r4_pkg SHALL hold N, C, DELAY, W defaults and the state enum.
REQ-034 Horner update SHALL live in sub-module sd_r4_accumulator (clear, load-enable, digit in, W-bit value out).
REQ-035 Digit counter SHALL be $clog2(N+2) bits, shared by SKIP and COLLECT.

Verification
REQ-036 start; en held high; zi after skip = 1,-2,0,0,0,0,0; expected=2048 -> done 10th cycle after start, value=2048, correct=1.
REQ-037 All seven accepted digits = 3 -> value=16383; all = -3 -> value=-16383; no digit_err.
REQ-038 Same as REQ-036 with en low every other cycle -> identical value, done delayed by stall count.
REQ-039 zi=3'b100 in third accepted digit -> digit_err=1 through done, cleared by next start.
REQ-040 start after 4 accepted digits -> counts restart, single done after full new run, old digits absent.
REQ-041 reset asserted mid-COLLECT -> outputs zero immediately, busy=0, no done pulse.
